// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } fetch_entry_t;

    localparam int unsigned FETCH_BYTES = 8;
    localparam logic [63:0] ALIGN_MASK  = 64'h7;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    function automatic logic [63:0] align_addr(input logic [63:0] addr);
        return addr & ~ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through circular buffer; clear has priority over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type T = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output T                         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    cnt;
    logic           do_push;
    logic           do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];

    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction-fetch front end: sequential 8-byte fetch requests with credit-based
// flow control, response buffering, and flush redirect that discards stale responses.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [63:0] BOOT_ADDR = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    input  logic        flush_i,
    input  logic [63:0] flush_addr_i,
    output logic [63:0] instr_if_address_o,
    output logic        instr_if_data_req_o,
    input  logic        instr_if_data_gnt_i,
    input  logic        instr_if_data_rvalid_i,
    input  logic [63:0] instr_if_data_rdata_i,
    output logic        fetch_valid_o,
    output logic [63:0] fetch_addr_o,
    output logic [63:0] fetch_rdata_o,
    input  logic        fetch_ready_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [63:0]   pc;
    logic [63:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_n;
    logic [CW-1:0] discard;
    logic [CW-1:0] discard_n;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    state_t        state;

    logic          empty;
    logic          full;
    logic          grant;
    logic          drop;
    logic          push;
    logic          pop;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    assign credit_used         = {1'b0, outstanding} + {1'b0, count};
    assign instr_if_data_req_o = fetch_en_i & ~flush_i & (state != IDLE)
                                 & (credit_used < (CW+1)'(DEPTH));
    assign instr_if_address_o  = pc;

    assign grant = instr_if_data_req_o & instr_if_data_gnt_i;
    assign drop  = instr_if_data_rvalid_i & (discard != '0);
    assign push  = instr_if_data_rvalid_i & ~drop & ~flush_i;

    assign fetch_valid_o = ~empty & ~flush_i;
    assign pop           = fetch_valid_o & fetch_ready_i;
    assign fetch_addr_o  = head.addr;
    assign fetch_rdata_o = head.data;

    assign push_entry.addr = resp_pc;
    assign push_entry.data = instr_if_data_rdata_i;

    // outstanding only tracks live requests; on flush every live request becomes
    // stale and migrates into discard, less any response landing this cycle.
    always_comb begin
        discard_n     = discard;
        outstanding_n = outstanding;
        if (flush_i) begin
            discard_n     = discard + outstanding - CW'(instr_if_data_rvalid_i);
            outstanding_n = '0;
        end else begin
            if (drop) discard_n = discard - CW'(1);
            outstanding_n = outstanding + CW'(grant) - CW'(instr_if_data_rvalid_i & ~drop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc          <= align_addr(BOOT_ADDR);
            resp_pc     <= align_addr(BOOT_ADDR);
            outstanding <= '0;
            discard     <= '0;
            state       <= IDLE;
        end else begin
            outstanding <= outstanding_n;
            discard     <= discard_n;
            state       <= (discard_n != '0) ? DRAIN : FETCH;
            if (flush_i) begin
                pc      <= align_addr(flush_addr_i);
                resp_pc <= align_addr(flush_addr_i);
            end else begin
                if (grant) pc      <= pc + 64'(FETCH_BYTES);
                if (push)  resp_pc <= resp_pc + 64'(FETCH_BYTES);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (flush_i),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

    overflow_chk: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full && !pop));

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer with an in-order variable-latency memory model.
module tb_instr_fetch_buffer;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [63:0] BOOT  = 64'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_en_i;
    logic        flush_i;
    logic [63:0] flush_addr_i;
    logic [63:0] instr_if_address_o;
    logic        instr_if_data_req_o;
    logic        instr_if_data_gnt_i;
    logic        instr_if_data_rvalid_i;
    logic [63:0] instr_if_data_rdata_i;
    logic        fetch_valid_o;
    logic [63:0] fetch_addr_o;
    logic [63:0] fetch_rdata_o;
    logic        fetch_ready_i;

    instr_fetch_buffer #(
        .DEPTH     (DEPTH),
        .BOOT_ADDR (BOOT)
    ) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .fetch_en_i             (fetch_en_i),
        .flush_i                (flush_i),
        .flush_addr_i           (flush_addr_i),
        .instr_if_address_o     (instr_if_address_o),
        .instr_if_data_req_o    (instr_if_data_req_o),
        .instr_if_data_gnt_i    (instr_if_data_gnt_i),
        .instr_if_data_rvalid_i (instr_if_data_rvalid_i),
        .instr_if_data_rdata_i  (instr_if_data_rdata_i),
        .fetch_valid_o          (fetch_valid_o),
        .fetch_addr_o           (fetch_addr_o),
        .fetch_rdata_o          (fetch_rdata_o),
        .fetch_ready_i          (fetch_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] data;
        int          due;
        bit          stale;
    } mem_t;

    mem_t         mem_q[$];
    fetch_entry_t sb[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          since_rst, buf_cnt, grants, pops, first_pop, serial;
    logic [63:0] model_pc, first_addr, last_pop_addr;
    logic        last_req, obs_valid;
    // stimulus controls: gnt_mode 0=never 1=always 2=random
    int          gnt_mode, lat_min, lat_max;
    logic        en_cmd, ready_cmd, flush_cmd;
    logic        rand_ready;
    logic [63:0] flush_tgt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic int live_count();
        int n = 0;
        foreach (mem_q[i]) if (!mem_q[i].stale) n++;
        return n;
    endfunction

    // One clock cycle: called and returns at a falling edge.
    task automatic step();
        logic         deliver;
        logic         req;
        logic         rdy;
        logic         exp_req;
        int           live;
        mem_t         m;
        fetch_entry_t e;
        logic [63:0]  d;

        rdy = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
        flush_i       = flush_cmd;
        flush_addr_i  = flush_tgt;
        fetch_en_i    = en_cmd;
        fetch_ready_i = rdy;
        deliver = (mem_q.size() > 0) && (mem_q[0].due <= since_rst);
        instr_if_data_rvalid_i = deliver;
        instr_if_data_rdata_i  = deliver ? mem_q[0].data : '0;
        live = live_count();
        #1;
        req     = instr_if_data_req_o;
        exp_req = en_cmd && !flush_cmd && (since_rst > 0) && (live + buf_cnt < DEPTH);
        check("req", 64'(req), 64'(exp_req));
        check("address", instr_if_address_o, model_pc);
        check("valid", 64'(fetch_valid_o), 64'(buf_cnt > 0 && !flush_cmd));
        last_req  = req;
        obs_valid = fetch_valid_o;
        case (gnt_mode)
            0:       instr_if_data_gnt_i = 1'b0;
            1:       instr_if_data_gnt_i = req;
            default: instr_if_data_gnt_i = req & 1'($urandom_range(0, 1));
        endcase

        if (fetch_valid_o && rdy) begin
            check("pop_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pop_addr", fetch_addr_o, e.addr);
                check("pop_data", fetch_rdata_o, e.data);
                buf_cnt--;
                pops++;
                last_pop_addr = fetch_addr_o;
                if (first_pop < 0) begin
                    first_pop  = since_rst;
                    first_addr = fetch_addr_o;
                end
            end
        end
        if (flush_cmd) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            sb.delete();
            buf_cnt  = 0;
            model_pc = flush_tgt & ~64'h7;
        end
        if (deliver) begin
            m = mem_q.pop_front();
            if (!m.stale) buf_cnt++;
            check("overflow", 64'(buf_cnt <= DEPTH), 64'd1);
        end
        if (req && instr_if_data_gnt_i) begin
            serial++;
            d = {32'(serial), model_pc[31:0] ^ 32'h5A5A_C3C3};
            mem_q.push_back('{data: d, due: since_rst + $urandom_range(lat_max, lat_min), stale: 1'b0});
            sb.push_back('{addr: model_pc, data: d});
            model_pc += 64'd8;
            grants++;
        end
        @(posedge clk_i);
        since_rst++;
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        fetch_en_i = 1'b0; flush_i = 1'b0; flush_addr_i = '0;
        instr_if_data_gnt_i = 1'b0; instr_if_data_rvalid_i = 1'b0;
        instr_if_data_rdata_i = '0; fetch_ready_i = 1'b0;
        mem_q.delete(); sb.delete();
        buf_cnt = 0; model_pc = BOOT; since_rst = 0; first_pop = -1;
        en_cmd = 1'b1; ready_cmd = 1'b1; flush_cmd = 1'b0; flush_tgt = '0;
        rand_ready = 1'b0; gnt_mode = 1; lat_min = 1; lat_max = 1;
        repeat (2) @(negedge clk_i);
        check("rst_req", 64'(instr_if_data_req_o), 64'd0);
        check("rst_addr", instr_if_address_o, BOOT);
        check("rst_valid", 64'(fetch_valid_o), 64'd0);
        rst_i = 1'b0;
    endtask

    initial begin
        int g0, p0, guard;
        serial = 0; grants = 0; pops = 0;

        // 1: streaming with single-cycle memory
        apply_reset();
        p0 = pops;
        repeat (20) step();
        check("t1_first_cycle", 64'(first_pop), 64'd3);
        check("t1_first_addr", first_addr, 64'h8000_0000);
        check("t1_throughput", 64'(pops - p0), 64'd17);

        // 2: consumer stalled, credits exhaust at DEPTH
        apply_reset();
        ready_cmd = 1'b0;
        g0 = grants;
        repeat (15) step();
        check("t2_grants", 64'(grants - g0), 64'(DEPTH));
        check("t2_req_blocked", 64'(last_req), 64'd0);
        ready_cmd = 1'b1; step(); ready_cmd = 1'b0;
        g0 = grants;
        repeat (10) step();
        check("t2_one_more", 64'(grants - g0), 64'd1);

        // 3: flush with two live requests in flight
        apply_reset();
        lat_min = 6; lat_max = 6;
        guard = 0;
        while (live_count() != 2 && guard < 20) begin step(); guard++; end
        check("t3_setup", 64'(live_count()), 64'd2);
        flush_cmd = 1'b1; flush_tgt = 64'h1234_5677;
        step();
        flush_cmd = 1'b0;
        check("t3_drain", 64'(dut.state), 64'(DRAIN));
        guard = 0;
        while (dut.state != FETCH && guard < 40) begin step(); guard++; end
        check("t3_fetch", 64'(dut.state), 64'(FETCH));
        first_pop = -1;
        guard = 0;
        while (first_pop < 0 && guard < 40) begin step(); guard++; end
        check("t3_first_addr", first_addr, 64'h1234_5670);

        // 4: flush coinciding with an rvalid while the buffer holds DEPTH-1 words
        apply_reset();
        ready_cmd = 1'b0;
        guard = 0;
        while (!(buf_cnt == DEPTH - 1 && mem_q.size() == 1 && mem_q[0].due <= since_rst) && guard < 20) begin
            step(); guard++;
        end
        check("t4_setup", 64'(buf_cnt), 64'(DEPTH - 1));
        flush_cmd = 1'b1; flush_tgt = 64'h4000;
        step();
        check("t4_valid_flush", 64'(obs_valid), 64'd0);
        flush_cmd = 1'b0;
        step();
        check("t4_valid_after", 64'(obs_valid), 64'd0);
        ready_cmd = 1'b1;
        repeat (10) step();

        // 5: address wrap and random grant/ready stalls
        apply_reset();
        gnt_mode = 2; rand_ready = 1'b1;
        step();
        flush_cmd = 1'b1; flush_tgt = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        flush_cmd = 1'b0;
        guard = 0;
        while (model_pc != 64'h0 && guard < 50) begin step(); guard++; end
        check("t5_wrap", instr_if_address_o, 64'h0);
        lat_min = 1; lat_max = 3;
        repeat (200) begin
            flush_cmd = ($urandom_range(0, 15) == 0);
            flush_tgt = {$urandom(), $urandom()};
            step();
        end
        flush_cmd = 1'b0;

        // 6: asynchronous reset with three requests in flight
        apply_reset();
        lat_min = 5; lat_max = 5;
        guard = 0;
        while (live_count() != 3 && guard < 20) begin step(); guard++; end
        check("t6_setup", 64'(live_count()), 64'd3);
        #2 rst_i = 1'b1;
        #1;
        check("t6_req", 64'(instr_if_data_req_o), 64'd0);
        check("t6_addr", instr_if_address_o, BOOT);
        check("t6_valid", 64'(fetch_valid_o), 64'd0);
        @(negedge clk_i);
        apply_reset();
        gnt_mode = 2; rand_ready = 1'b1; lat_min = 1; lat_max = 2;
        repeat (40) step();

        en_cmd = 1'b0; rand_ready = 1'b0; ready_cmd = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 40) begin step(); guard++; end
        check("final_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
